// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the RV32I fetch stage.
package instr_fetch_unit_pkg;

   localparam int unsigned XLEN = 32;

   typedef logic [XLEN-1:0] data_bus;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      VALID = 2'd2,
      TRAP  = 2'd3
   } fetch_state_t;

   localparam data_bus NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit_pc_next.sv
// Next-PC selection: sequential PC+4 or word-aligned branch/jump target.
module instr_fetch_unit_pc_next
   import instr_fetch_unit_pkg::*;
(
   input  data_bus pc,
   input  logic    pc_sel,
   input  data_bus target,
   output data_bus pc_next,
   output data_bus pc_plus4,
   output logic    misalign
);

   // 32-bit modulo add; the carry out is intentionally dropped
   assign pc_plus4 = pc + XLEN'(4);

   // Low target bits are cleared; a misaligned target is reported separately
   assign pc_next  = pc_sel ? {target[XLEN-1:2], 2'b00} : pc_plus4;
   assign misalign = pc_sel && (target[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC register, imem req/ack handshake, held instruction.
// FETCH_MISALIGN_TRAP_EN enables the sticky TRAP state on misaligned targets.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter data_bus RESET_PC = 32'h0000_0000
) (
   input  logic    clk_i,
   input  logic    rst_i,
   output logic    imem_req_o,
   output data_bus imem_addr_o,
   input  logic    imem_ack_i,
   input  data_bus imem_rdata_i,
   input  logic    stall_i,
   input  logic    pc_sel_i,
   input  data_bus target_i,
   output logic    instr_valid_o,
   output data_bus instruction_o,
   output data_bus pc_o,
   output data_bus pc_plus4_o,
   output logic    misalign_o
);

   fetch_state_t state_q, state_d;
   data_bus      pc_q, pc_d;
   data_bus      instr_q, instr_d;
   data_bus      pc_next;
   logic         target_misalign;
   logic         req_q, valid_q;

   instr_fetch_unit_pc_next u_pc_next (
      .pc       (pc_q),
      .pc_sel   (pc_sel_i),
      .target   (target_i),
      .pc_next  (pc_next),
      .pc_plus4 (pc_plus4_o),
      .misalign (target_misalign)
   );

   // Next-state, next-PC and instruction capture
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      case (state_q)
         IDLE:  state_d = FETCH;
         FETCH: begin
            if (imem_ack_i) begin
               instr_d = imem_rdata_i;
               state_d = VALID;
            end
         end
         VALID: begin
            if (!stall_i) begin
`ifdef FETCH_MISALIGN_TRAP_EN
               if (target_misalign) begin
                  state_d = TRAP;
               end else begin
                  pc_d    = pc_next;
                  state_d = FETCH;
               end
`else
               pc_d    = pc_next;
               state_d = FETCH;
`endif
            end
         end
         default: state_d = state_q;
      endcase
   end

   // Status outputs are registered copies of the next state
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         req_q   <= (state_d == FETCH);
         valid_q <= (state_d == VALID);
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misalign_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) misalign_q <= 1'b0;
      else       misalign_q <= (state_d == TRAP);
   end

   assign misalign_o = misalign_q;
`else
   logic unused_misalign;
   assign unused_misalign = target_misalign;
   assign misalign_o      = 1'b0;
`endif

   assign imem_req_o    = req_q;
   assign instr_valid_o = valid_q;
   assign imem_addr_o   = pc_q;
   assign pc_o          = pc_q;
   assign instruction_o = instr_q;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the RV32I core: owns the program counter, requests instructions from instruction memory over a req/ack handshake, and holds the fetched word stable on `instruction_o` for the immediate generator and decoder. When the core accepts the instruction, the next PC is selected: sequential PC+4 or a branch/jump target supplied by the execute path.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `clk_i`  in  1: single clock, rising edge.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `imem_req_o`  out  1: fetch request to instruction memory.
- `imem_addr_o`  out  32 (`data_bus`): fetch address, equals `pc_o`.
- `imem_ack_i`  in  1: memory has `imem_rdata_i` valid this cycle.
- `imem_rdata_i`  in  32 (`data_bus`): instruction word from memory.
- `stall_i`  in  1: core not ready to consume the held instruction.
- `pc_sel_i`  in  1: 0 = next PC is PC+4, 1 = next PC is `target_i`.
- `target_i`  in  32 (`data_bus`): branch/jump target.
- `instr_valid_o`  out  1: `instruction_o` and `pc_o` describe a valid fetched instruction.
- `instruction_o`  out  32 (`data_bus`): held instruction, feeds imm gen `instruction_i`.
- `pc_o`  out  32 (`data_bus`): PC of the held or in-flight instruction.
- `pc_plus4_o`  out  32 (`data_bus`): `pc_o + 4`, for JAL/JALR link.
- `misalign_o`  out  1: misaligned-target trap flag (see Configuration).

## Operation
- FSM states:
  - IDLE: no request.
  - FETCH: `imem_req_o`=1; waits for `imem_ack_i`.
  - VALID: instruction held.
  - TRAP: only with the macro.
- IDLE -> FETCH unconditionally on the first clock edge after reset release.
- FETCH:
  - `imem_req_o` and `imem_addr_o` are held stable until ack.
  - On `imem_ack_i`=1, `imem_rdata_i` is registered into `instruction_o` -> VALID.
  - Without ack, stay in FETCH; no timeout.
- VALID:
  - `instr_valid_o`=1.
  - If `stall_i`=1, hold all outputs.
  - If `stall_i`=0, the instruction is accepted: PC <= (`pc_sel_i` ? `target_i` : PC+4) -> FETCH.
- `imem_ack_i` in IDLE, VALID or TRAP is ignored; `imem_rdata_i` is not sampled.
- `pc_sel_i` and `target_i` are sampled only in the acceptance cycle.
- PC arithmetic is 32-bit modulo: `32'hFFFF_FFFC` + 4 = `32'h0000_0000`; no carry out.
- `pc_plus4_o` is combinational from the PC register.
- Reset values (async, any state, mid-handshake included):
  - state IDLE, PC = `RESET_PC`
  - `imem_req_o`=0, `instr_valid_o`=0, `misalign_o`=0
  - `instruction_o`=`NOP_INSTR` (`32'h0000_0013`)
- An outstanding request is abandoned on reset; a late ack is ignored because the FSM is in IDLE.

## Timing
- All state, PC and `instruction_o` registers update on the `clk_i` rising edge.
- `imem_req_o` and `instr_valid_o` are decoded from the state register only (no input-to-output combinational path).
- Minimum fetch latency with zero-wait memory:
  - cycle 0: FETCH with ack.
  - cycle 1: VALID.
  - Throughput is one instruction per 2 cycles; each memory wait cycle adds 1.
- After reset release: IDLE for 1 cycle, request asserted in cycle 2.
- The acceptance cycle (VALID, `stall_i`=0) is followed by FETCH with the new `imem_addr_o`.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - At acceptance with `pc_sel_i`=1 and `target_i[1:0]`≠0, PC is not updated and the FSM enters TRAP.
  - In TRAP: `misalign_o`=1, `imem_req_o`=0, `instr_valid_o`=0, `pc_o` holds the faulting instruction's PC.
  - TRAP is left only by reset.
- Not defined:
  - `target_i[1:0]` is forced to `2'b00` on load.
  - `misalign_o` is tied 0 and the TRAP state does not exist.

## Structure
- `RISCV32i_Pack` gains:
  - `fetch_state_t` enum {IDLE, FETCH, VALID, TRAP}
  - `NOP_INSTR` constant `32'h0000_0013`
  - `data_bus` reused for all 32-bit ports.
- One combinational sub-module, `pc_next`: inputs PC, `pc_sel_i`, `target_i`; outputs next PC, `pc_plus4`, misalign flag. The top holds the FSM and registers.

## Test plan
- Reset, then zero-wait ack with rdata `32'h00A00113`:
  - `imem_addr_o`=0 in FETCH.
  - Next cycle `instr_valid_o`=1, `instruction_o`=`32'h00A00113`, `pc_plus4_o`=4.
- Memory with 3 wait cycles:
  - req and addr stable for 4 cycles.
  - `instruction_o` unchanged (`NOP_INSTR`) until the cycle after ack.
- `stall_i`=1 for 5 cycles in VALID: outputs frozen. Release with `pc_sel_i`=1, `target_i`=`32'h0000_0100` -> next `imem_addr_o`=`32'h100`.
- `RESET_PC`=`32'hFFFF_FFFC`, accept with `pc_sel_i`=0 -> next `imem_addr_o`=`32'h0000_0000`.
- Assert `rst_i` during FETCH, then pulse `imem_ack_i` during reset and in IDLE:
  - `instr_valid_o` stays 0, `instruction_o`=`NOP_INSTR`.
  - The fetch restarts at `RESET_PC`.
- Accept with `target_i`=`32'h0000_0102`:
  - With the macro: `misalign_o`=1, no further requests.
  - Without the macro: next `imem_addr_o`=`32'h100`.
